// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared constants for the memory handshake controller.
// Ack polarity, timeout defaults and the error-source encoding.
package mem_handshake_ctrl_pkg;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 5;

    localparam logic ACK_ASSERTED = 1'b0;
    localparam logic ACK_IDLE     = 1'b1;

    typedef enum logic {
        ERR_INST = 1'b0,
        ERR_DATA = 1'b1
    } err_src_e;

    function automatic logic ack_seen(input logic ack_n);
        return ack_n == ACK_ASSERTED;
    endfunction

endpackage

// File: rtl/mem_handshake_ctrl_channel.sv
// One memory channel: held flag, done term and capture strobe.
// The held flag remembers an ack that arrived while the core was frozen.
module hs_channel
    import mem_handshake_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack_n,
    input  logic stall,
    input  logic freeze,
    output logic held,
    output logic done,
    output logic take
);

    logic held_q;
    logic ack;

    assign ack  = ack_seen(ack_n);
    assign held = held_q;
    assign done = held_q | ack;

    // Only a first, requested ack during a live stall is latched.
    assign take = stall & ~freeze & req & ack & ~held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= 1'b0;
        end else if (freeze) begin
            held_q <= held_q;
        end else if (!stall) begin
            held_q <= 1'b0;
        end else if (take) begin
            held_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Instruction/data bus handshake sequencer with global freeze,
// early-instruction buffering and a sticky timeout error.
module mem_handshake_ctrl
    import mem_handshake_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        data_req,
    input  logic        data_we,
    input  logic        ACKI_n,
    input  logic        ACKD_n,
    input  logic [31:0] idt_in,
    output logic        mreq,
    output logic        write,
    output logic [31:0] inst_out,
    output logic        stall,
    output logic        bus_err,
    output logic        err_is_data
);

    logic             i_held;
    logic             i_done;
    logic             i_take;
    logic             d_held;
    logic             d_done;
    logic             d_take;
    logic             i_wait;
    logic             d_wait;
    logic             busy;
    logic [31:0]      inst_buf;
    logic [CNT_W-1:0] cnt;
    err_src_e         err_src;

    assign i_wait = fetch_req & ~i_done;
    assign d_wait = data_req & ~d_done;
    assign busy   = bus_err | i_wait | d_wait;

    hs_channel u_ichan (
        .clk    (clk),
        .rst    (rst),
        .req    (fetch_req),
        .ack_n  (ACKI_n),
        .stall  (busy),
        .freeze (bus_err),
        .held   (i_held),
        .done   (i_done),
        .take   (i_take)
    );

    hs_channel u_dchan (
        .clk    (clk),
        .rst    (rst),
        .req    (data_req),
        .ack_n  (ACKD_n),
        .stall  (busy),
        .freeze (bus_err),
        .held   (d_held),
        .done   (d_done),
        .take   (d_take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_buf <= '0;
        end else if (i_take) begin
            inst_buf <= idt_in;
        end
    end

    // The counter stops once bus_err is set, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bus_err <= 1'b0;
            err_src <= ERR_INST;
        end else if (bus_err) begin
            cnt     <= cnt;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
                bus_err <= 1'b1;
                err_src <= d_wait ? ERR_DATA : ERR_INST;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign err_is_data = (err_src == ERR_DATA);

    assign stall    = ~rst & busy;
    assign mreq     = ~rst & data_req & ~d_held & ~bus_err;
    assign write    = mreq & data_we;
    assign inst_out = (~rst & i_held) ? inst_buf : idt_in;

    logic unused_take;
    assign unused_take = d_take;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Self-checking bench for mem_handshake_ctrl.
// Directed scenarios plus randomized traffic against a reference model.
module tb_mem_handshake_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        data_req;
    logic        data_we;
    logic        ACKI_n;
    logic        ACKD_n;
    logic [31:0] idt_in;
    logic        mreq;
    logic        write;
    logic [31:0] inst_out;
    logic        stall;
    logic        bus_err;
    logic        err_is_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_handshake_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .data_req    (data_req),
        .data_we     (data_we),
        .ACKI_n      (ACKI_n),
        .ACKD_n      (ACKD_n),
        .idt_in      (idt_in),
        .mreq        (mreq),
        .write       (write),
        .inst_out    (inst_out),
        .stall       (stall),
        .bus_err     (bus_err),
        .err_is_data (err_is_data)
    );

    // Reference model: which accesses of the current cycle are already
    // satisfied, the saved word, and how long the core has been frozen.
    bit        m_igot;
    bit        m_dgot;
    bit [31:0] m_word;
    int        m_frozen;
    bit        m_err;
    bit        m_errd;

    bit        e_stall;
    bit        e_mreq;
    bit        e_write;
    bit [31:0] e_inst;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic model_expect();
        bit iok;
        bit dok;
        iok = m_igot || !ACKI_n;
        dok = m_dgot || !ACKD_n;
        if (rst) begin
            e_stall = 0;
            e_mreq  = 0;
            e_write = 0;
            e_inst  = idt_in;
        end else begin
            e_stall = m_err || (fetch_req && !iok) || (data_req && !dok);
            e_mreq  = data_req && !m_dgot && !m_err;
            e_write = e_mreq && data_we;
            e_inst  = m_igot ? m_word : idt_in;
        end
    endtask

    task automatic model_edge();
        bit dpend;
        model_expect();
        dpend = data_req && !(m_dgot || !ACKD_n);
        if (rst) begin
            m_igot = 0; m_dgot = 0; m_word = 0;
            m_frozen = 0; m_err = 0; m_errd = 0;
        end else if (m_err) begin
        end else if (e_stall) begin
            if (fetch_req && !ACKI_n && !m_igot) begin
                m_igot = 1;
                m_word = idt_in;
            end
            if (data_req && !ACKD_n) m_dgot = 1;
            m_frozen++;
            if (m_frozen == TO) begin
                m_err  = 1;
                m_errd = dpend;
            end
        end else begin
            m_igot = 0; m_dgot = 0; m_frozen = 0;
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 0; data_req = 0; data_we = 0;
        ACKI_n = 1; ACKD_n = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        fetch_req = 1; data_req = 1; data_we = 1;
        ACKI_n = 1; ACKD_n = 1;
        idt_in = 32'hCAFE_0001;
        settle();
        n_chk++;
        if (stall !== 1'b0 || mreq !== 1'b0 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: stall=%b mreq=%b write=%b want 000",
                     stall, mreq, write);
        end
        n_chk++;
        if (inst_out !== idt_in) begin
            n_fail++;
            $display("FAIL reset_inst: got %h want %h", inst_out, idt_in);
        end
        tick();
        n_chk++;
        if (bus_err !== 1'b0 || err_is_data !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: bus_err=%b err_is_data=%b want 00",
                     bus_err, err_is_data);
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_wait();
        fetch_req = 1; data_req = 1; data_we = 0;
        ACKI_n = 0; ACKD_n = 0;
        for (int i = 0; i < 4; i++) begin
            idt_in = $urandom;
            settle();
            n_chk++;
            if (stall !== 1'b0 || mreq !== 1'b1 || inst_out !== idt_in) begin
                n_fail++;
                $display("FAIL zero_wait[%0d]: stall=%b mreq=%b inst=%h want 0 1 %h",
                         i, stall, mreq, inst_out, idt_in);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_data_wait();
        fetch_req = 1; data_req = 1; data_we = 0;
        ACKI_n = 0; ACKD_n = 1;
        idt_in = 32'h0050_0093;
        settle();
        n_chk++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL dwait_c0: stall=%b want 1", stall);
        end
        tick();
        idt_in = 32'hDEAD_BEEF;
        for (int i = 1; i < 3; i++) begin
            settle();
            n_chk++;
            if (stall !== 1'b1 || mreq !== 1'b1 || inst_out !== 32'h0050_0093) begin
                n_fail++;
                $display("FAIL dwait_c%0d: stall=%b mreq=%b inst=%h want 1 1 00500093",
                         i, stall, mreq, inst_out);
            end
            tick();
        end
        ACKD_n = 0;
        settle();
        n_chk++;
        if (stall !== 1'b0 || inst_out !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL dwait_ack: stall=%b inst=%h want 0 00500093",
                     stall, inst_out);
        end
        tick();
        idt_in = 32'h1111_2222;
        settle();
        n_chk++;
        if (inst_out !== 32'h1111_2222 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL dwait_release: inst=%h stall=%b want 11112222 0",
                     inst_out, stall);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_iwait();
        fetch_req = 1; data_req = 1; data_we = 1;
        ACKI_n = 1; ACKD_n = 0;
        idt_in = 32'h0000_0013;
        settle();
        n_chk++;
        if (write !== 1'b1 || mreq !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL store_c0: write=%b mreq=%b stall=%b want 1 1 1",
                     write, mreq, stall);
        end
        tick();
        ACKD_n = 1;
        settle();
        n_chk++;
        if (write !== 1'b0 || mreq !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL store_c1: write=%b mreq=%b stall=%b want 0 0 1",
                     write, mreq, stall);
        end
        tick();
        ACKI_n = 0;
        settle();
        n_chk++;
        if (write !== 1'b0 || mreq !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_c2: write=%b mreq=%b stall=%b want 0 0 0",
                     write, mreq, stall);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int early;
        fetch_req = 0; data_req = 1; data_we = 1;
        ACKI_n = 0; ACKD_n = 1;
        early = 0;
        for (int i = 0; i < TO; i++) begin
            settle();
            if (bus_err !== 1'b0) early++;
            tick();
        end
        n_chk++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL timeout_early: bus_err seen %0d cycles want 0", early);
        end
        ACKD_n = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_chk++;
            if (bus_err !== 1'b1 || err_is_data !== 1'b1 ||
                stall !== 1'b1 || mreq !== 1'b0 || write !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_d[%0d]: err=%b isd=%b stall=%b mreq=%b want 1 1 1 0",
                         i, bus_err, err_is_data, stall, mreq);
            end
            tick();
        end
        rst = 1;
        settle();
        n_chk++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_rst_stall: stall=%b want 0", stall);
        end
        tick();
        rst = 0;
        idle_inputs();
        settle();
        n_chk++;
        if (bus_err !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleared: err=%b stall=%b want 0 0", bus_err, stall);
        end
        fetch_req = 1; ACKI_n = 1;
        for (int i = 0; i < TO; i++) tick();
        settle();
        n_chk++;
        if (bus_err !== 1'b1 || err_is_data !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_i: err=%b isd=%b want 1 0", bus_err, err_is_data);
        end
        do_reset();
        idle_inputs();
        fetch_req = 1; data_req = 1;
        for (int i = 0; i < TO; i++) tick();
        settle();
        n_chk++;
        if (bus_err !== 1'b1 || err_is_data !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_both: err=%b isd=%b want 1 1", bus_err, err_is_data);
        end
        do_reset();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midwait();
        int early;
        fetch_req = 1; data_req = 1; data_we = 0;
        ACKI_n = 0; ACKD_n = 1;
        idt_in = 32'h1234_5678;
        tick();
        idt_in = 32'hAAAA_5555;
        for (int i = 0; i < 9; i++) tick();
        settle();
        n_chk++;
        if (inst_out !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL midwait_held: inst=%h want 12345678", inst_out);
        end
        rst = 1;
        settle();
        n_chk++;
        if (inst_out !== 32'hAAAA_5555 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_in_rst: inst=%h stall=%b want aaaa5555 0",
                     inst_out, stall);
        end
        tick();
        rst = 0;
        ACKI_n = 1;
        idt_in = 32'h0BAD_F00D;
        settle();
        n_chk++;
        if (inst_out !== 32'h0BAD_F00D || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_after: inst=%h stall=%b want 0badf00d 1",
                     inst_out, stall);
        end
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (bus_err !== 1'b0) early++;
        end
        n_chk++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL midwait_cnt: bus_err early %0d cycles want 0", early);
        end
        tick();
        n_chk++;
        if (bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_cnt_end: bus_err=%b want 1", bus_err);
        end
        do_reset();
        idle_inputs();
        tick();
    endtask

    task automatic test_spurious();
        fetch_req = 0; data_req = 0; data_we = 1;
        for (int i = 0; i < 6; i++) begin
            ACKI_n = i[0];
            ACKD_n = ~i[1];
            idt_in = $urandom;
            settle();
            n_chk++;
            if (stall !== 1'b0 || mreq !== 1'b0 || write !== 1'b0 || inst_out !== idt_in) begin
                n_fail++;
                $display("FAIL spurious[%0d]: stall=%b mreq=%b inst=%h want 0 0 %h",
                         i, stall, mreq, inst_out, idt_in);
            end
            tick();
        end
        fetch_req = 1; data_req = 1;
        ACKI_n = 1; ACKD_n = 1;
        settle();
        n_chk++;
        if (stall !== 1'b1 || mreq !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_nohold: stall=%b mreq=%b want 1 1", stall, mreq);
        end
        ACKI_n = 0; ACKD_n = 0;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int bad;
        int pi;
        int pd;
        bad = 0;
        m_igot = 0; m_dgot = 0; m_word = 0;
        m_frozen = 0; m_err = 0; m_errd = 0;
        rst = 1;
        idle_inputs();
        model_edge();
        tick();
        pi = 2; pd = 2;
        for (int c = 0; c < 1500; c++) begin
            if (c % 24 == 0) begin
                pi = $urandom_range(0, 7);
                pd = $urandom_range(0, 7);
            end
            rst       = ($urandom_range(0, 59) == 0);
            fetch_req = $urandom_range(0, 3) != 0;
            data_req  = $urandom_range(0, 1);
            data_we   = $urandom_range(0, 1);
            ACKI_n    = $urandom_range(0, 7) >= pi;
            ACKD_n    = $urandom_range(0, 7) >= pd;
            idt_in    = $urandom;
            settle();
            model_expect();
            n_chk++;
            if (stall !== e_stall || mreq !== e_mreq || write !== e_write ||
                inst_out !== e_inst || bus_err !== m_err ||
                (m_err && err_is_data !== m_errd)) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: st=%b mr=%b wr=%b in=%h be=%b ed=%b want %b %b %b %h %b %b",
                             c, stall, mreq, write, inst_out, bus_err, err_is_data,
                             e_stall, e_mreq, e_write, e_inst, m_err, m_errd);
            end
            @(posedge clk);
            model_edge();
            #1;
        end
        do_reset();
        idle_inputs();
        tick();
    endtask

    initial begin
        idt_in = 0;
        idle_inputs();
        rst = 1;
        tick();
        test_reset();
        test_zero_wait();
        test_data_wait();
        test_store_iwait();
        test_timeout();
        test_reset_midwait();
        test_spurious();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
